// File: rtl/e203_exu_flush_pkg.sv
// Types and defaults shared by the EXU flush/halt responder and the exception unit.
// The state encoding is shared so both sides can decode the responder state.
package e203_exu_flush_pkg;

    localparam int unsigned PC_W_DEF  = 32;
    localparam int unsigned TMO_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FL_DRAIN = 3'd1,
        ST_FL_REDIR = 3'd2,
        ST_HL_DRAIN = 3'd3,
        ST_HALTED   = 3'd4
    } flush_halt_st_e;

    function automatic logic is_drain(input flush_halt_st_e st);
        return (st == ST_FL_DRAIN) || (st == ST_HL_DRAIN);
    endfunction

endpackage

// File: rtl/e203_sat_cnt.sv
// Saturating up-counter with synchronous clear and enable.
// The max flag reflects the registered count and stays high while saturated.
module e203_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic max_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign max_o = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !max_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/e203_exu_flush_halt_resp.sv
// Responder for the exception unit's flush and WFI-halt handshakes: drains the IFU
// (and the OITF for halts), redirects the IFU on flush, and returns the acks.
module e203_exu_flush_halt_resp
    import e203_exu_flush_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned TMO_W = TMO_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_req,
    input  logic [PC_W-1:0] flush_pc,
    output logic            flush_ack,
    input  logic            wfi_halt_ifu_req,
    input  logic            wfi_halt_exu_req,
    output logic            wfi_halt_ifu_ack,
    output logic            wfi_halt_exu_ack,
    input  logic            ifu_outstanding,
    input  logic            oitf_empty,
    output logic            ifu_halt,
    output logic            ifu_redir_valid,
    output logic [PC_W-1:0] ifu_redir_pc,
    input  logic            ifu_redir_ready,
    output logic            drain_tmo
);

    flush_halt_st_e  state_q, state_d;
    logic [PC_W-1:0] redir_pc_q, redir_pc_d;
    logic            flush_ack_q, flush_ack_d;
    logic            ifu_halt_q, ifu_halt_d;
    logic            redir_valid_q, redir_valid_d;
    logic            ifu_ack_q, ifu_ack_d;
    logic            exu_ack_q, exu_ack_d;
    logic            drain_tmo_q, drain_tmo_d;
    logic            cnt_en;
    logic            cnt_max;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d    = ST_FL_DRAIN;
                    redir_pc_d = flush_pc;
                end else if (wfi_halt_ifu_req) begin
                    state_d = ST_HL_DRAIN;
                end
            end
            ST_FL_DRAIN: begin
                if (!ifu_outstanding) state_d = ST_FL_REDIR;
            end
            ST_FL_REDIR: begin
                if (redir_valid_q && ifu_redir_ready) state_d = ST_IDLE;
            end
            ST_HL_DRAIN: begin
                // A flush (e.g. interrupt) abandons the halt without acking it.
                if (flush_req) begin
                    state_d    = ST_FL_DRAIN;
                    redir_pc_d = flush_pc;
                end else if (!wfi_halt_ifu_req) begin
                    state_d = ST_IDLE;
                end else if (!ifu_outstanding && oitf_empty) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (flush_req) begin
                    state_d    = ST_FL_DRAIN;
                    redir_pc_d = flush_pc;
                end else if (!wfi_halt_ifu_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        flush_ack_d   = (state_q == ST_FL_REDIR) && redir_valid_q && ifu_redir_ready;
        ifu_halt_d    = (state_d != ST_IDLE);
        redir_valid_d = (state_d == ST_FL_REDIR);
        ifu_ack_d     = (state_d == ST_HALTED);
        exu_ack_d     = (state_d == ST_HALTED) && wfi_halt_exu_req && oitf_empty;
        drain_tmo_d   = drain_tmo_q | cnt_max;
    end

    assign cnt_en = is_drain(state_q);

    e203_sat_cnt #(
        .W (TMO_W)
    ) u_drain_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!cnt_en),
        .en    (cnt_en),
        .max_o (cnt_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            redir_pc_q    <= '0;
            flush_ack_q   <= 1'b0;
            ifu_halt_q    <= 1'b0;
            redir_valid_q <= 1'b0;
            ifu_ack_q     <= 1'b0;
            exu_ack_q     <= 1'b0;
            drain_tmo_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            redir_pc_q    <= redir_pc_d;
            flush_ack_q   <= flush_ack_d;
            ifu_halt_q    <= ifu_halt_d;
            redir_valid_q <= redir_valid_d;
            ifu_ack_q     <= ifu_ack_d;
            exu_ack_q     <= exu_ack_d;
            drain_tmo_q   <= drain_tmo_d;
        end
    end

    assign flush_ack        = flush_ack_q;
    assign ifu_halt         = ifu_halt_q;
    assign ifu_redir_valid  = redir_valid_q;
    assign ifu_redir_pc     = redir_pc_q;
    assign wfi_halt_ifu_ack = ifu_ack_q;
    assign wfi_halt_exu_ack = exu_ack_q;
    // Visible as soon as the counter saturates; the sticky flop holds it afterwards.
    assign drain_tmo        = drain_tmo_q | cnt_max;

endmodule

// File: tb/tb_e203_exu_flush_halt_resp.sv
// Directed bench for e203_exu_flush_halt_resp; expected values are hand-derived
// from the flush/halt protocol timing.
module tb_e203_exu_flush_halt_resp;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned TMO_W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush_req;
    logic [PC_W-1:0] flush_pc;
    logic            flush_ack;
    logic            wfi_halt_ifu_req;
    logic            wfi_halt_exu_req;
    logic            wfi_halt_ifu_ack;
    logic            wfi_halt_exu_ack;
    logic            ifu_outstanding;
    logic            oitf_empty;
    logic            ifu_halt;
    logic            ifu_redir_valid;
    logic [PC_W-1:0] ifu_redir_pc;
    logic            ifu_redir_ready;
    logic            drain_tmo;

    int n_vec = 0;
    int n_err = 0;

    e203_exu_flush_halt_resp #(
        .PC_W  (PC_W),
        .TMO_W (TMO_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_req        (flush_req),
        .flush_pc         (flush_pc),
        .flush_ack        (flush_ack),
        .wfi_halt_ifu_req (wfi_halt_ifu_req),
        .wfi_halt_exu_req (wfi_halt_exu_req),
        .wfi_halt_ifu_ack (wfi_halt_ifu_ack),
        .wfi_halt_exu_ack (wfi_halt_exu_ack),
        .ifu_outstanding  (ifu_outstanding),
        .oitf_empty       (oitf_empty),
        .ifu_halt         (ifu_halt),
        .ifu_redir_valid  (ifu_redir_valid),
        .ifu_redir_pc     (ifu_redir_pc),
        .ifu_redir_ready  (ifu_redir_ready),
        .drain_tmo        (drain_tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Snapshot of all single-bit outputs: {flush_ack, ifu_halt, redir_valid, ifu_ack, exu_ack, drain_tmo}
    function automatic logic [31:0] outs();
        return {26'd0, flush_ack, ifu_halt, ifu_redir_valid,
                wfi_halt_ifu_ack, wfi_halt_exu_ack, drain_tmo};
    endfunction

    task automatic idle_inputs();
        flush_req        = 1'b0;
        flush_pc         = '0;
        wfi_halt_ifu_req = 1'b0;
        wfi_halt_exu_req = 1'b0;
        ifu_outstanding  = 1'b0;
        oitf_empty       = 1'b1;
        ifu_redir_ready  = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #12;
        check("reset_outs", outs(), 32'h00);
        check("reset_pc", ifu_redir_pc, 32'h0);
        rst = 1'b0;
        tick();
        check("idle_outs", outs(), 32'h00);

        // 1: IFU idle, ready high: ack three edges after the request is sampled.
        flush_req = 1'b1;
        flush_pc  = 32'h8000_0100;
        tick();
        check("t1_drain", outs(), 32'b010000);
        tick();
        check("t1_redir", outs(), 32'b011000);
        check("t1_pc", ifu_redir_pc, 32'h8000_0100);
        tick();
        check("t1_ack", outs(), 32'b100000);
        flush_req = 1'b0;
        tick();
        check("t1_after", outs(), 32'h00);

        // 2: outstanding fetch holds the drain; slow redirect keeps pc stable.
        ifu_outstanding = 1'b1;
        ifu_redir_ready = 1'b0;
        flush_req       = 1'b1;
        flush_pc        = 32'hCAFE_0008;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_drain", outs(), 32'b010000);
        end
        ifu_outstanding = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_wait", outs(), 32'b011000);
            check("t2_pc", ifu_redir_pc, 32'hCAFE_0008);
        end
        ifu_redir_ready = 1'b1;
        tick();
        check("t2_ack", outs(), 32'b100000);
        flush_req = 1'b0;
        tick();
        check("t2_after", outs(), 32'h00);

        // 3: halt waits on the OITF; acks hold, then clear one edge after reqs drop.
        wfi_halt_ifu_req = 1'b1;
        wfi_halt_exu_req = 1'b1;
        oitf_empty       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_drain", outs(), 32'b010000);
        end
        oitf_empty = 1'b1;
        tick();
        check("t3_halted", outs(), 32'b010110);
        tick();
        check("t3_hold", outs(), 32'b010110);
        wfi_halt_ifu_req = 1'b0;
        wfi_halt_exu_req = 1'b0;
        tick();
        check("t3_release", outs(), 32'h00);

        // 4: interrupt wake from HALTED with halt reqs still high.
        wfi_halt_ifu_req = 1'b1;
        wfi_halt_exu_req = 1'b1;
        tick();
        tick();
        check("t4_halted", outs(), 32'b010110);
        flush_req = 1'b1;
        flush_pc  = 32'h0000_0040;
        tick();
        check("t4_drain", outs(), 32'b010000);
        tick();
        check("t4_redir", outs(), 32'b011000);
        check("t4_pc", ifu_redir_pc, 32'h0000_0040);
        tick();
        check("t4_ack", outs(), 32'b100000);
        flush_req        = 1'b0;
        wfi_halt_ifu_req = 1'b0;
        wfi_halt_exu_req = 1'b0;
        tick();
        check("t4_single_ack", outs(), 32'h00);

        // 5: simultaneous flush and halt: flush wins, no halt acks.
        flush_req        = 1'b1;
        flush_pc         = 32'h1234_5678;
        wfi_halt_ifu_req = 1'b1;
        wfi_halt_exu_req = 1'b1;
        tick();
        check("t5_drain", outs(), 32'b010000);
        tick();
        check("t5_redir", outs(), 32'b011000);
        check("t5_pc", ifu_redir_pc, 32'h1234_5678);
        tick();
        check("t5_ack", outs(), 32'b100000);
        idle_inputs();
        tick();
        check("t5_after", outs(), 32'h00);

        // 7: request withdrawn mid-drain still completes the captured redirect.
        ifu_outstanding = 1'b1;
        flush_req       = 1'b1;
        flush_pc        = 32'hA5A5_0000;
        tick();
        flush_req = 1'b0;
        flush_pc  = 32'h0;
        tick();
        ifu_outstanding = 1'b0;
        tick();
        check("t7_redir", outs(), 32'b011000);
        check("t7_pc", ifu_redir_pc, 32'hA5A5_0000);
        tick();
        check("t7_ack", outs(), 32'b100000);
        tick();
        check("t7_after", outs(), 32'h00);

        // 6: stuck fetch: timeout after 255 drain edges, then async reset.
        ifu_outstanding = 1'b1;
        flush_req       = 1'b1;
        flush_pc        = 32'hDEAD_BEEC;
        tick();
        for (int i = 0; i < 254; i++) tick();
        check("t6_pre_tmo", outs(), 32'b010000);
        tick();
        check("t6_tmo", outs(), 32'b010001);
        for (int i = 0; i < 45; i++) tick();
        check("t6_sticky", outs(), 32'b010001);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_rst", outs(), 32'h00);
        check("t6_rst_pc", ifu_redir_pc, 32'h0);
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("t6_post_rst", outs(), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
